// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_FU functional units in
// per-unit FIFOs and grants up to four of them per cycle onto the CDB lanes.
module cdb_arbiter #(
   parameter int NUM_FU     = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NUM_FU-1:0]     fu_valid,
   input  logic [4*NUM_FU-1:0]   fu_rob_index,
   input  logic [16*NUM_FU-1:0]  fu_result,
   output logic [NUM_FU-1:0]     fu_ready,
   output logic                  cdb_valid     [0:3],
   output logic [3:0]            cdb_rob_index [0:3],
   output logic [15:0]           cdb_result    [0:3],
   output logic                  busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(NUM_FU);

   logic [19:0]    mem_q   [0:NUM_FU-1][0:FIFO_DEPTH-1];
   logic [PW-1:0]  head_q  [0:NUM_FU-1];
   logic [PW-1:0]  tail_q  [0:NUM_FU-1];
   logic [CW-1:0]  count_q [0:NUM_FU-1];
   logic [SW-1:0]  rr_q;
   logic [SW-1:0]  rr_d;

   logic [NUM_FU-1:0] push_s;
   logic [NUM_FU-1:0] grant_s;
   logic              lane_vld_s [0:3];
   logic [SW-1:0]     lane_src_s [0:3];
   logic [19:0]       lane_rec_s [0:3];
   logic [SW:0]       scan_s;
   logic [2:0]        gcnt_s;
   logic [SW-1:0]     last_s;

   // Source handshake and occupancy status, all from registered counts.
   always_comb begin
      fu_ready = {NUM_FU{1'b0}};
      push_s   = {NUM_FU{1'b0}};
      busy     = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = rst_n & (count_q[i] < CW'(FIFO_DEPTH));
         push_s[i]   = fu_valid[i] & fu_ready[i] & ~flush;
         busy        = busy | (count_q[i] != {CW{1'b0}});
      end
   end

   // Round-robin scan from rr_q; the first four non-empty FIFOs take lanes 0..3.
   always_comb begin
      grant_s = {NUM_FU{1'b0}};
      gcnt_s  = 3'd0;
      last_s  = {SW{1'b0}};
      scan_s  = {(SW+1){1'b0}};
      for (int l = 0; l < 4; l++) begin
         lane_vld_s[l] = 1'b0;
         lane_src_s[l] = {SW{1'b0}};
      end
      for (int k = 0; k < NUM_FU; k++) begin
         scan_s = {1'b0, rr_q} + (SW+1)'(k);
         if (scan_s >= (SW+1)'(NUM_FU)) begin
            scan_s = scan_s - (SW+1)'(NUM_FU);
         end else begin
            scan_s = scan_s;
         end
         if ((count_q[scan_s[SW-1:0]] != {CW{1'b0}}) && (gcnt_s < 3'd4)) begin
            grant_s[scan_s[SW-1:0]] = 1'b1;
            lane_vld_s[gcnt_s[1:0]] = 1'b1;
            lane_src_s[gcnt_s[1:0]] = scan_s[SW-1:0];
            last_s                  = scan_s[SW-1:0];
            gcnt_s                  = gcnt_s + 3'd1;
         end else begin
            gcnt_s = gcnt_s;
         end
      end
      if (gcnt_s != 3'd0) begin
         rr_d = (last_s == SW'(NUM_FU - 1)) ? {SW{1'b0}} : last_s + SW'(1);
      end else begin
         rr_d = rr_q;
      end
   end

   // Head entry of the FIFO feeding each lane.
   always_comb begin
      for (int l = 0; l < 4; l++) begin
         lane_rec_s[l] = mem_q[lane_src_s[l]][head_q[lane_src_s[l]]];
      end
   end

   // FIFO pointers, counts and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q <= {SW{1'b0}};
         for (int i = 0; i < NUM_FU; i++) begin
            head_q[i]  <= {PW{1'b0}};
            tail_q[i]  <= {PW{1'b0}};
            count_q[i] <= {CW{1'b0}};
         end
      end else if (flush) begin
         for (int i = 0; i < NUM_FU; i++) begin
            head_q[i]  <= {PW{1'b0}};
            tail_q[i]  <= {PW{1'b0}};
            count_q[i] <= {CW{1'b0}};
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NUM_FU; i++) begin
            if (push_s[i]) begin
               tail_q[i] <= tail_q[i] + PW'(1);
            end
            if (grant_s[i]) begin
               head_q[i] <= head_q[i] + PW'(1);
            end
            case ({push_s[i], grant_s[i]})
               2'b10:   count_q[i] <= count_q[i] + CW'(1);
               2'b01:   count_q[i] <= count_q[i] - CW'(1);
               default: count_q[i] <= count_q[i];
            endcase
         end
      end
   end

   // FIFO storage; push_s is already suppressed during reset and flush.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push_s[i]) begin
            mem_q[i][tail_q[i]] <= {fu_rob_index[4*i +: 4], fu_result[16*i +: 16]};
         end
      end
   end

   // CDB lane registers; index/result hold while a lane is idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int l = 0; l < 4; l++) begin
            cdb_valid[l]     <= 1'b0;
            cdb_rob_index[l] <= 4'd0;
            cdb_result[l]    <= 16'd0;
         end
      end else if (flush) begin
         for (int l = 0; l < 4; l++) begin
            cdb_valid[l] <= 1'b0;
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            cdb_valid[l] <= lane_vld_s[l];
            if (lane_vld_s[l]) begin
               cdb_rob_index[l] <= lane_rec_s[l][19:16];
               cdb_result[l]    <= lane_rec_s[l][15:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run, all checked
// against a list-based model of the per-source buffers and round-robin grant.
module tb_cdb_arbiter;

   localparam int N = 6;
   localparam int D = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [N-1:0]      fu_valid;
   logic [4*N-1:0]    fu_rob_index;
   logic [16*N-1:0]   fu_result;
   logic [N-1:0]      fu_ready;
   logic              cdb_valid     [0:3];
   logic [3:0]        cdb_rob_index [0:3];
   logic [15:0]       cdb_result    [0:3];
   logic              busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: each source is an ordered list of at most D pending results.
   logic [19:0]  mbuf [0:N-1][0:D-1];
   int           mcnt [0:N-1];
   int           m_rr;
   logic [N-1:0] m_acc;
   logic         exp_v   [0:3];
   logic [3:0]   exp_rob [0:3];
   logic [15:0]  exp_res [0:3];

   cdb_arbiter #(.NUM_FU(N), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fu_valid(fu_valid), .fu_rob_index(fu_rob_index), .fu_result(fu_result),
      .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
      .cdb_result(cdb_result), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] model_rdy();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = rst_n && (mcnt[i] < D);
      return r;
   endfunction

   function automatic logic model_busy();
      logic b = 1'b0;
      for (int i = 0; i < N; i++) if (mcnt[i] > 0) b = 1'b1;
      return b;
   endfunction

   task automatic set_src(input int i, input logic [3:0] r, input logic [15:0] v);
      fu_valid[i]          = 1'b1;
      fu_rob_index[4*i+:4] = r;
      fu_result[16*i+:16]  = v;
   endtask

   // Advance one clock and apply the model's rules for that edge.
   task automatic step();
      logic [N-1:0] rdy;
      int gc, last, idx;
      @(posedge clk);
      cyc++;
      rdy   = model_rdy();
      m_acc = fu_valid & rdy;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mcnt[i] = 0;
         m_rr = 0;
         for (int l = 0; l < 4; l++) begin
            exp_v[l] = 1'b0; exp_rob[l] = 4'd0; exp_res[l] = 16'd0;
         end
      end else if (flush) begin
         for (int i = 0; i < N; i++) mcnt[i] = 0;
         for (int l = 0; l < 4; l++) exp_v[l] = 1'b0;
      end else begin
         for (int l = 0; l < 4; l++) exp_v[l] = 1'b0;
         gc = 0; last = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (mcnt[idx] > 0 && gc < 4) begin
               {exp_rob[gc], exp_res[gc]} = mbuf[idx][0];
               for (int j = 0; j < D - 1; j++) mbuf[idx][j] = mbuf[idx][j+1];
               mcnt[idx]--;
               exp_v[gc] = 1'b1;
               gc++;
               last = idx;
            end
         end
         if (last >= 0) m_rr = (last + 1) % N;
         for (int i = 0; i < N; i++) begin
            if (m_acc[i]) begin
               mbuf[i][mcnt[i]] = {fu_rob_index[4*i+:4], fu_result[16*i+:16]};
               mcnt[i]++;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; fu_valid = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; fu_valid = '1;
      fu_rob_index = {$urandom, $urandom};
      fu_result    = {$urandom, $urandom, $urandom};
      step();
      step();
      checks++;
      if (fu_ready !== 6'b000000) begin
         errors++; $display("FAIL reset_ready got=%b exp=000000", fu_ready);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b exp=0", busy);
      end
      for (int l = 0; l < 4; l++) begin
         checks++;
         if (cdb_valid[l] !== 1'b0 || cdb_rob_index[l] !== 4'd0 || cdb_result[l] !== 16'd0) begin
            errors++;
            $display("FAIL reset_lane%0d got v=%b rob=%h res=%h exp v=0 rob=0 res=0",
                     l, cdb_valid[l], cdb_rob_index[l], cdb_result[l]);
         end
      end
      rst_n = 1'b1; fu_valid = '0;
      #1;
      checks++;
      if (fu_ready !== 6'b111111) begin
         errors++; $display("FAIL release_ready got=%b exp=111111", fu_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      set_src(2, 4'h5, 16'hBEEF);
      step();
      fu_valid = '0;
      checks++;
      if (busy !== 1'b1 || cdb_valid[0] !== 1'b0) begin
         errors++; $display("FAIL single_t1 got busy=%b v0=%b exp busy=1 v0=0", busy, cdb_valid[0]);
      end
      step();
      checks++;
      if (cdb_valid[0] !== 1'b1 || cdb_rob_index[0] !== 4'h5 || cdb_result[0] !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_lane0 got v=%b rob=%h res=%h exp v=1 rob=5 res=beef",
                  cdb_valid[0], cdb_rob_index[0], cdb_result[0]);
      end
      checks++;
      if (cdb_valid[1] !== 1'b0 || cdb_valid[2] !== 1'b0 || cdb_valid[3] !== 1'b0) begin
         errors++; $display("FAIL single_other got v1..3=%b%b%b exp 000",
                            cdb_valid[1], cdb_valid[2], cdb_valid[3]);
      end
      step();
      checks++;
      if (cdb_valid[0] !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_t3 got v0=%b busy=%b exp 0 0", cdb_valid[0], busy);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) set_src(i, 4'(i), 16'h1000 + 16'(i));
      step();
      fu_valid = '0;
      step();
      for (int l = 0; l < 4; l++) begin
         checks++;
         if (cdb_valid[l] !== 1'b1 || cdb_rob_index[l] !== 4'(l) || cdb_result[l] !== 16'h1000 + 16'(l)) begin
            errors++;
            $display("FAIL rr_first_lane%0d got v=%b rob=%h res=%h exp v=1 rob=%h",
                     l, cdb_valid[l], cdb_rob_index[l], cdb_result[l], l);
         end
      end
      step();
      checks++;
      if (cdb_valid[0] !== 1'b1 || cdb_rob_index[0] !== 4'd4 || cdb_valid[1] !== 1'b1 ||
          cdb_rob_index[1] !== 4'd5 || cdb_valid[2] !== 1'b0 || cdb_valid[3] !== 1'b0) begin
         errors++;
         $display("FAIL rr_second got v=%b%b%b%b rob0=%h rob1=%h exp v=1100 rob0=4 rob1=5",
                  cdb_valid[0], cdb_valid[1], cdb_valid[2], cdb_valid[3],
                  cdb_rob_index[0], cdb_rob_index[1]);
      end
      // rr_ptr should now be 0: source 0 must win lane 0 over source 1.
      set_src(1, 4'h9, 16'h0009);
      set_src(0, 4'h7, 16'h0007);
      step();
      fu_valid = '0;
      step();
      checks++;
      if (cdb_rob_index[0] !== 4'h7 || cdb_rob_index[1] !== 4'h9) begin
         errors++; $display("FAIL rr_ptr_zero got rob0=%h rob1=%h exp 7 9",
                            cdb_rob_index[0], cdb_rob_index[1]);
      end
   endtask

   task automatic test_fairness_wrap();
      do_reset();
      set_src(3, 4'h3, 16'h0003);
      step();
      fu_valid = '0;
      step();
      for (int i = 0; i < N; i++) if (i == 0 || i == 1 || i == 4 || i == 5)
         set_src(i, 4'(8 + i), 16'h3000 + 16'(i));
      step();
      fu_valid = '0;
      step();
      checks++;
      if (cdb_rob_index[0] !== 4'hC || cdb_rob_index[1] !== 4'hD || cdb_rob_index[2] !== 4'h8 ||
          cdb_rob_index[3] !== 4'h9 || cdb_valid[3] !== 1'b1 || cdb_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_order got rob=%h %h %h %h exp c d 8 9",
                  cdb_rob_index[0], cdb_rob_index[1], cdb_rob_index[2], cdb_rob_index[3]);
      end
      // rr_ptr should now be 2: source 2 ahead of source 1.
      set_src(1, 4'h1, 16'h0001);
      set_src(2, 4'h2, 16'h0002);
      step();
      fu_valid = '0;
      step();
      checks++;
      if (cdb_rob_index[0] !== 4'h2 || cdb_rob_index[1] !== 4'h1) begin
         errors++; $display("FAIL wrap_rr_two got rob0=%h rob1=%h exp 2 1",
                            cdb_rob_index[0], cdb_rob_index[1]);
      end
   endtask

   task automatic test_full_fifo();
      logic [N-1:0] others [0:3];
      int s0_k = 0;
      int seen = 0;
      others[0] = 6'b001000; others[1] = 6'b110010;
      others[2] = 6'b111100; others[3] = 6'b011110;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         fu_valid = '0;
         if (c < 4) for (int i = 1; i < N; i++)
            if (others[c][i]) set_src(i, 4'(i), 16'h2000 + 16'(c * 16 + i));
         if (c >= 2 && s0_k < 3) set_src(0, 4'hA + 4'(s0_k), 16'hA000 + 16'(s0_k));
         step();
         if (c >= 2 && m_acc[0]) s0_k++;
         for (int l = 0; l < 4; l++) begin
            checks++;
            if (cdb_valid[l] !== exp_v[l] || cdb_rob_index[l] !== exp_rob[l] || cdb_result[l] !== exp_res[l]) begin
               errors++;
               $display("FAIL full_lane%0d c=%0d got v=%b rob=%h res=%h exp v=%b rob=%h res=%h",
                        l, c, cdb_valid[l], cdb_rob_index[l], cdb_result[l], exp_v[l], exp_rob[l], exp_res[l]);
            end
            if (cdb_valid[l] === 1'b1 && cdb_rob_index[l] >= 4'hA && cdb_rob_index[l] <= 4'hC) seen++;
         end
         if (c == 3) begin
            checks++;
            if (fu_ready[0] !== 1'b0 || s0_k != 2) begin
               errors++; $display("FAIL full_drop got ready0=%b accepted=%0d exp 0 2", fu_ready[0], s0_k);
            end
         end
         if (c == 4) begin
            checks++;
            if (fu_ready[0] !== 1'b1 || s0_k != 2) begin
               errors++; $display("FAIL full_reopen got ready0=%b accepted=%0d exp 1 2", fu_ready[0], s0_k);
            end
         end
      end
      checks++;
      if (seen != 3 || s0_k != 3 || busy !== 1'b0) begin
         errors++; $display("FAIL full_delivery got seen=%0d accepted=%0d busy=%b exp 3 3 0", seen, s0_k, busy);
      end
   endtask

   task automatic test_flush();
      int bad = 0;
      do_reset();
      set_src(0, 4'h1, 16'h1111);
      set_src(1, 4'h2, 16'h2222);
      set_src(2, 4'h3, 16'h3333);
      step();
      fu_valid = '0;
      flush = 1'b1;
      set_src(3, 4'hF, 16'hDEAD);
      step();
      flush = 1'b0; fu_valid = '0;
      checks++;
      if (cdb_valid[0] !== 1'b0 || cdb_valid[1] !== 1'b0 || cdb_valid[2] !== 1'b0 ||
          cdb_valid[3] !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_clear got v=%b%b%b%b busy=%b exp 0000 0",
                            cdb_valid[0], cdb_valid[1], cdb_valid[2], cdb_valid[3], busy);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         for (int l = 0; l < 4; l++) if (cdb_valid[l] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL flush_no_broadcast got valid_lanes=%0d exp 0", bad);
      end
   endtask

   task automatic test_random();
      logic          have [0:N-1];
      logic [3:0]    irob [0:N-1];
      logic [15:0]   ires [0:N-1];
      for (int i = 0; i < N; i++) have[i] = 1'b0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         fu_valid = '0;
         for (int i = 0; i < N; i++) begin
            if (!have[i] && $urandom_range(0, 99) < 55) begin
               have[i] = 1'b1;
               irob[i] = 4'($urandom_range(0, 15));
               ires[i] = 16'($urandom);
            end
            if (have[i]) set_src(i, irob[i], ires[i]);
         end
         flush = ($urandom_range(0, 39) == 0);
         rst_n = ($urandom_range(0, 149) != 0);
         step();
         for (int i = 0; i < N; i++) if (m_acc[i]) have[i] = 1'b0;
         rst_n = 1'b1; flush = 1'b0;
         #1;
         for (int l = 0; l < 4; l++) begin
            checks++;
            if (cdb_valid[l] !== exp_v[l] || cdb_rob_index[l] !== exp_rob[l] || cdb_result[l] !== exp_res[l]) begin
               errors++;
               $display("FAIL rand_lane%0d cyc=%0d got v=%b rob=%h res=%h exp v=%b rob=%h res=%h",
                        l, cyc, cdb_valid[l], cdb_rob_index[l], cdb_result[l], exp_v[l], exp_rob[l], exp_res[l]);
            end
         end
         checks++;
         if (fu_ready !== model_rdy() || busy !== model_busy()) begin
            errors++;
            $display("FAIL rand_status cyc=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                     cyc, fu_ready, busy, model_rdy(), model_busy());
         end
      end
   endtask

   initial begin
      fu_valid = '0; fu_rob_index = '0; fu_result = '0;
      rst_n = 1'b0; flush = 1'b0; m_rr = 0; m_acc = '0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness_wrap();
      test_full_fifo();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
